// File: rtl/line_store_responder.sv
// ============================================================================
// line_store_responder
// In-order line store: writes commit in one cycle, reads respond after DELAY.
// Rev 1.0
// ============================================================================
`default_nettype none

module line_store_responder #(
    parameter int DELAY     = 5,
    parameter int DEPTH     = 4,
    parameter int LINE_BITS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  addr_in,
    input  logic [127:0] data_in,
    input  logic         rden,
    input  logic         wren,
    output logic         req_ready,
    output logic [127:0] data_out,
    output logic         data_out_valid,
    output logic         proto_err
);

    localparam int NLINES = 1 << LINE_BITS;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = 4;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITE     = 2'd1;
    localparam logic [1:0] S_READ_WAIT = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [CNT_W-1:0]     cnt;
    logic [LINE_BITS-1:0] eng_line;
    logic [127:0]         eng_data;

    logic [127:0]         mem [NLINES];
    logic [NLINES-1:0]    written;

    logic                 q_wr   [DEPTH];
    logic [LINE_BITS-1:0] q_line [DEPTH];
    logic [127:0]         q_data [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W:0]       count;

    logic                 engine_free;
    logic                 fire;
    logic                 commit;
    logic                 req_any;
    logic                 accept;
    logic                 bad;
    logic                 q_empty;
    logic                 pop;
    logic                 bypass;
    logic                 push;
    logic                 start;
    logic                 start_wr;
    logic [LINE_BITS-1:0] start_line;
    logic [127:0]         start_data;
    logic [127:0]         sample;
    logic [LINE_BITS-1:0] req_line;
    logic                 unused_addr;

    assign req_line    = addr_in[LINE_BITS+3:4];
    assign unused_addr = ^{addr_in[31:LINE_BITS+4], addr_in[3:0]};

    assign req_ready = (count < (PTR_W+1)'(DEPTH));
    assign req_any   = rden | wren;
    assign accept    = reset & req_any & req_ready;
    assign bad       = reset & req_any & (~req_ready | (rden & wren));
    assign q_empty   = (count == '0);

    // The freeing edge doubles as a start edge: queue head first, else the new request.
    assign pop        = engine_free & ~q_empty;
    assign bypass     = engine_free & q_empty & accept;
    assign push       = accept & ~bypass;
    assign start      = pop | bypass;
    assign start_wr   = pop ? q_wr[rd_ptr]   : wren;
    assign start_line = pop ? q_line[rd_ptr] : req_line;
    assign start_data = pop ? q_data[rd_ptr] : data_in;

    // A write committing on the same edge must be visible to the read starting there.
    always_comb begin
        sample = '0;
        if (commit && (eng_line == start_line)) begin
            sample = eng_data;
        end else if (written[start_line]) begin
            sample = mem[start_line];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = start_wr ? S_WRITE : S_READ_WAIT;
        end else if (engine_free) begin
            state_next = S_IDLE;
        end
    end

    always_comb begin
        engine_free = 1'b0;
        fire        = 1'b0;
        commit      = 1'b0;
        case (state)
            S_IDLE: begin
                engine_free = 1'b1;
            end
            S_WRITE: begin
                engine_free = 1'b1;
                commit      = 1'b1;
            end
            S_READ_WAIT: begin
                if (cnt == '0) begin
                    engine_free = 1'b1;
                    fire        = 1'b1;
                end
            end
            default: begin
                engine_free = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt            <= '0;
            count          <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            written        <= '0;
            proto_err      <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= fire;
            if (fire) begin
                data_out <= eng_data;
            end
            if (bad) begin
                proto_err <= 1'b1;
            end
            if (commit) begin
                written[eng_line] <= 1'b1;
            end
            if (start && !start_wr) begin
                cnt <= CNT_W'(DELAY - 1);
            end else if ((state == S_READ_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Storage arrays carry no reset; the written bits gate what is readable.
    always_ff @(posedge clk) begin
        if (reset && commit) begin
            mem[eng_line] <= eng_data;
        end
        if (start) begin
            eng_line <= start_line;
            eng_data <= start_wr ? start_data : sample;
        end
        if (push) begin
            q_wr[wr_ptr]   <= wren;
            q_line[wr_ptr] <= req_line;
            q_data[wr_ptr] <= data_in;
        end
    end

endmodule

`default_nettype wire
